cw_nco_keyer_tx: RTL and testbench
==================================

Name: cw_nco_keyer_tx

Overview:
- Parametrised keyed-carrier transmitter for the Tang board. Generalises the fixed clk/2 key-toggled output.
- Debounces the raw active-low key and generates a programmable-frequency square carrier from a phase-accumulator NCO.
- Sequences keying through IDLE/KEYED/HANG so tx_en (PTT) holds across inter-element gaps.
- Also drives key and heartbeat LEDs; sits directly between the top-level pins and the RF output pin.

Parameters:
ACC_W, 24, NCO phase accumulator width in bits; tx_out frequency = f_clk * freq_word / 2^ACC_W
DEB_CYCLES, 270000, consecutive stable samples required to accept a key change (10 ms at 27 MHz); must be >= 1
HANG_CYCLES, 5400000, cycles tx_en is held after key release (200 ms); 0 = no hang
BLINK_CYCLES, 8388608, status_led half-period in cycles; must be >= 1
TIMEOUT_CYCLES, 810000000, maximum continuous KEYED time (30 s); used only with TX_TIMEOUT_EN

Ports:
clk_27MHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key  in  1  raw key switch, 0 = pressed, asynchronous to the clock
freq_word  in  ACC_W  NCO increment; latched on IDLE->KEYED only
tx_out  out  1  keyed carrier, MSB of phase accumulator when carrier gated on, else 0
tx_en  out  1  PTT, high in KEYED and HANG
key_led  out  1  debounced key state: 1 = released, 0 = pressed
status_led  out  1  heartbeat square wave

Behaviour:
- Reset (rst_n low, async assert; deassert synchronised in-block by a 2-flop chain):
  - All outputs 0 except key_led = 1.
  - State IDLE, accumulator 0, debounced key = released, sync flops = 1 (released), all counters 0.
- Key path:
  - key passes a 2-flop synchroniser. A stability counter resets whenever the synchronised level equals key_db.
  - When the level differs from key_db for DEB_CYCLES consecutive cycles, key_db updates on that cycle.
  - Pulses shorter than DEB_CYCLES are ignored.
  - key_led is registered from key_db.
- State machine, registered, one transition per cycle:
  - IDLE: tx_en=0, tx_out=0, accumulator held at 0.
    - key_db pressed -> KEYED; freq_word latched into freq_q; accumulator cleared.
  - KEYED: tx_en=1; accumulator += freq_q each cycle, modulo 2^ACC_W (wraps silently); tx_out = acc[ACC_W-1].
    - key_db released -> HANG, hang counter loaded with HANG_CYCLES.
    - If HANG_CYCLES=0 -> IDLE directly.
  - HANG: tx_en=1, tx_out=0, accumulator keeps running (phase-continuous on re-key), freq_q unchanged.
    - key_db pressed -> KEYED.
    - Counter decrements each cycle; -> IDLE on the cycle it reaches 1.
    - Press and expiry on the same cycle: KEYED wins.
- Latency:
  - Raw key edge (stable) to key_db change: DEB_CYCLES+2 cycles.
  - key_db to state/tx_en change: +1 cycle.
  - tx_out gated to 0 the same cycle the state leaves KEYED; no extra pipeline.
- freq_word changes while KEYED/HANG are ignored. freq_word=0 gives a constant tx_out=0 with tx_en=1.
- status_led: free-running counter 0..BLINK_CYCLES-1, toggles on wrap, independent of keying.
- Reset mid-transmission: tx_out and tx_en drop asynchronously and immediately; the state machine restarts in IDLE.

Optional Feature:
TX_TIMEOUT_EN
- Defined:
  - A KEYED-time counter (cleared on entry to KEYED from IDLE; held, not cleared, through HANG) forces state LOCKOUT when it reaches TIMEOUT_CYCLES.
  - LOCKOUT: tx_en=0, tx_out=0, status_led driven constant 1.
  - LOCKOUT exits to IDLE only after key_db is released.
  - IDLE->KEYED is blocked on the exit cycle.
- Undefined: no LOCKOUT state, no timeout counter; unlimited KEYED time; status_led always heartbeat.

Test Plan:
1. Reset defaults (ACC_W=8, DEB_CYCLES=4, HANG_CYCLES=10, BLINK_CYCLES=16): assert rst_n=0 mid-cycle -> tx_out=0, tx_en=0, key_led=1, status_led=0 immediately; after release, status_led toggles every 16 cycles.
2. Debounce: key low for 3 cycles then high -> no key_led or tx_en change. Key low held -> key_led=0 at cycle 6, tx_en=1 at cycle 7 after the first sampling edge.
3. NCO frequency: freq_word=64 then key pressed -> tx_out pattern 0,0,1,1 repeating (period 4). freq_word=128 -> tx_out toggles every cycle. Changing freq_word to 32 while KEYED leaves period 4.
4. Hang/re-key: release key -> tx_out=0 at once, tx_en held exactly 10 cycles after state exit, then 0. Re-press within hang -> back to KEYED with phase continuing (no accumulator clear).
5. HANG_CYCLES=0: release key -> tx_en and tx_out both 0 on the cycle state leaves KEYED.
6. With TX_TIMEOUT_EN, TIMEOUT_CYCLES=50: hold key -> after 50 KEYED cycles tx_en=0, status_led=1 constant. Key still held -> stays locked. Release, then press again -> normal KEYED.

Source files
------------

// File: rtl/cw_nco_keyer_tx.sv
// cw_nco_keyer_tx: debounced CW key, phase-accumulator square carrier, IDLE/KEYED/HANG PTT sequencing, LEDs.
// Optional build macro TX_TIMEOUT_EN adds a KEYED-time limit that forces a LOCKOUT state.
module cw_nco_keyer_tx #(
  parameter int ACC_W        = 24,
  parameter int DEB_CYCLES   = 270000,
  parameter int HANG_CYCLES  = 5400000,
  parameter int BLINK_CYCLES = 8388608
`ifdef TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 810000000
`endif
) (
  input  logic             clk_27MHz,
  input  logic             rst_n,
  input  logic             key,
  input  logic [ACC_W-1:0] freq_word,
  output logic             tx_out,
  output logic             tx_en,
  output logic             key_led,
  output logic             status_led
);
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int HANG_W  = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES + 1) : 1;
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
`ifdef TX_TIMEOUT_EN
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEYED = 2'd1,
    HANG  = 2'd2
`ifdef TX_TIMEOUT_EN
    , LOCKOUT = 2'd3
`endif
  } state_t;

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;
  logic [1:0]         key_sync_q;
  logic               key_db_q, key_db_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   freq_q, freq_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [HANG_W-1:0]  hang_q, hang_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               lock_s;
  logic               tx_out_q, tx_en_q, status_q;
`ifdef TX_TIMEOUT_EN
  logic [TO_W-1:0]    to_q, to_d;
`endif

  // Reset asserts asynchronously but leaves reset only after two clean clock edges.
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  // Debounce: key_db follows the synchronised key only after DEB_CYCLES differing cycles.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    if (key_sync_q[1] != key_db_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        key_db_d  = key_sync_q[1];
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Heartbeat divider, independent of keying.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  // Keying sequencer; the accumulator keeps running through HANG so a re-key is phase-continuous.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    acc_d   = acc_q;
    hang_d  = hang_q;
`ifdef TX_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (!key_db_q) begin
          state_d = KEYED;
          freq_d  = freq_word;
`ifdef TX_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      KEYED: begin
        acc_d = acc_q + freq_q;
`ifdef TX_TIMEOUT_EN
        to_d  = to_q + TO_W'(1);
        if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = LOCKOUT;
          acc_d   = '0;
        end else
`endif
        if (key_db_q) begin
          if (HANG_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HANG;
            hang_d  = HANG_W'(HANG_CYCLES);
          end
        end else begin
          state_d = KEYED;
        end
      end
      HANG: begin
        acc_d = acc_q + freq_q;
        if (!key_db_q) begin
          state_d = KEYED;
        end else if (hang_q == HANG_W'(1)) begin
          state_d = IDLE;
        end else begin
          hang_d = hang_q - HANG_W'(1);
        end
      end
`ifdef TX_TIMEOUT_EN
      LOCKOUT: begin
        acc_d = '0;
        if (key_db_q) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKOUT;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

`ifdef TX_TIMEOUT_EN
  assign lock_s = (state_d == LOCKOUT);
`else
  assign lock_s = 1'b0;
`endif

  // State and output registers; outputs are built from next-state so they change with the state.
  always_ff @(posedge clk_27MHz or negedge rst_int_n) begin
    if (!rst_int_n) begin
      key_sync_q  <= 2'b11;
      key_db_q    <= 1'b1;
      deb_cnt_q   <= '0;
      state_q     <= IDLE;
      freq_q      <= '0;
      acc_q       <= '0;
      hang_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      tx_out_q    <= 1'b0;
      tx_en_q     <= 1'b0;
      status_q    <= 1'b0;
`ifdef TX_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      key_sync_q  <= {key_sync_q[0], key};
      key_db_q    <= key_db_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      freq_q      <= freq_d;
      acc_q       <= acc_d;
      hang_q      <= hang_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tx_out_q    <= (state_d == KEYED) & acc_d[ACC_W-1];
      tx_en_q     <= (state_d == KEYED) | (state_d == HANG);
      status_q    <= blink_d | lock_s;
`ifdef TX_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_en      = tx_en_q;
  assign key_led    = key_db_q;
  assign status_led = status_q;
endmodule

// File: tb/tb_cw_nco_keyer_tx.sv
// Directed bench for cw_nco_keyer_tx: ACC_W=8, DEB_CYCLES=4, BLINK_CYCLES=16, HANG_CYCLES=10 (dut) and 0 (dut0).
module tb_cw_nco_keyer_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key = 1'b1;
  logic [7:0] freq_word = 8'd64;
  logic       tx_out, tx_en, key_led, status_led;
  logic       tx_out0, tx_en0, key_led0, status_led0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  cw_nco_keyer_tx #(
    .ACC_W(8), .DEB_CYCLES(4), .HANG_CYCLES(10), .BLINK_CYCLES(16)
`ifdef TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk_27MHz(clk), .rst_n(rst_n), .key(key), .freq_word(freq_word),
    .tx_out(tx_out), .tx_en(tx_en), .key_led(key_led), .status_led(status_led)
  );

  cw_nco_keyer_tx #(
    .ACC_W(8), .DEB_CYCLES(4), .HANG_CYCLES(0), .BLINK_CYCLES(16)
`ifdef TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut0 (
    .clk_27MHz(clk), .rst_n(rst_n), .key(key), .freq_word(freq_word),
    .tx_out(tx_out0), .tx_en(tx_en0), .key_led(key_led0), .status_led(status_led0)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_tx_out", tx_out, 1'b0);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_key_led", key_led, 1'b1);
    chk("rst_status", status_led, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(10);

    // 3-cycle glitch must be rejected
    key = 1'b0;
    step(3);
    key = 1'b1;
    step(8);
    chk("glitch_key_led", key_led, 1'b1);
    chk("glitch_tx_en", tx_en, 1'b0);

    // debounce latency and NCO with freq_word=64
    key = 1'b0;
    step(5);
    chk("deb_e5_key_led", key_led, 1'b1);
    step(1);
    chk("deb_e6_key_led", key_led, 1'b0);
    chk("deb_e6_tx_en", tx_en, 1'b0);
    step(1);
    chk("deb_e7_tx_en", tx_en, 1'b1);
    chk("deb_e7_tx_out", tx_out, 1'b0);
    freq_word = 8'd32;
    pat = 8'b0110_0110;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("nco64_pattern", tx_out, pat[7-i]);
    end

    // release: hang on dut, direct exit on dut0
    key = 1'b1;
    step(6);
    chk("rel_e20_tx_en", tx_en, 1'b1);
    chk("rel_e20_tx_en0", tx_en0, 1'b1);
    step(1);
    chk("hang_tx_out", tx_out, 1'b0);
    chk("hang_tx_en", tx_en, 1'b1);
    chk("nohang_tx_en0", tx_en0, 1'b0);
    chk("nohang_tx_out0", tx_out0, 1'b0);
    step(9);
    chk("hang_last_tx_en", tx_en, 1'b1);
    step(1);
    chk("hang_expired_tx_en", tx_en, 1'b0);

    // re-key during hang keeps the accumulator phase
    freq_word = 8'd64;
    key = 1'b0;
    step(7);
    chk("rk_keyed_tx_en", tx_en, 1'b1);
    step(1);
    key = 1'b1;
    step(7);
    chk("rk_hang_tx_en", tx_en, 1'b1);
    chk("rk_hang_tx_out", tx_out, 1'b0);
    key = 1'b0;
    step(6);
    chk("rk_e21_tx_out", tx_out, 1'b0);
    chk("rk_e21_tx_en", tx_en, 1'b1);
    step(1);
    chk("rk_phase_e22", tx_out, 1'b1);
    step(1);
    chk("rk_phase_e23", tx_out, 1'b0);
    step(2);
    chk("rk_phase_e25", tx_out, 1'b1);
    key = 1'b1;
    step(20);
    chk("rk_idle_tx_en", tx_en, 1'b0);

    // freq_word=128 toggles every cycle
    freq_word = 8'd128;
    key = 1'b0;
    step(7);
    chk("nco128_e7", tx_out, 1'b0);
    step(1);
    chk("nco128_e8", tx_out, 1'b1);
    step(1);
    chk("nco128_e9", tx_out, 1'b0);
    step(1);
    chk("nco128_e10", tx_out, 1'b1);
    step(2);
    chk("nco128_e12", tx_out, 1'b1);
    chk("pre_rst_tx_en", tx_en, 1'b1);

    // asynchronous reset mid-transmission
    #2 rst_n = 1'b0;
    key = 1'b1;
    #1;
    chk("midrst_tx_out", tx_out, 1'b0);
    chk("midrst_tx_en", tx_en, 1'b0);
    chk("midrst_key_led", key_led, 1'b1);
    chk("midrst_status", status_led, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(17);
    chk("blink_before_1st", status_led, 1'b0);
    step(1);
    chk("blink_1st", status_led, 1'b1);
    step(15);
    chk("blink_before_2nd", status_led, 1'b1);
    step(1);
    chk("blink_2nd", status_led, 1'b0);

`ifdef TX_TIMEOUT_EN
    key = 1'b0;
    step(56);
    chk("to_last_keyed", tx_en, 1'b1);
    step(1);
    chk("to_lock_tx_en", tx_en, 1'b0);
    chk("to_lock_tx_out", tx_out, 1'b0);
    chk("to_lock_status", status_led, 1'b1);
    step(20);
    chk("to_held_tx_en", tx_en, 1'b0);
    chk("to_held_status", status_led, 1'b1);
    key = 1'b1;
    step(7);
    chk("to_exit_tx_en", tx_en, 1'b0);
    key = 1'b0;
    step(7);
    chk("to_rekey_tx_en", tx_en, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
